// File: rtl/ddr4_phy_ctrl_pkg.sv
// Shared types and constants for the DDR4 PHY fabric-side controllers.
// Covers delay-tap state encoding and step direction codes.
package ddr4_phy_ctrl_pkg;

  localparam int TAP_W_DEF = 8;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_MOVE,
    ST_LOAD,
    ST_SETTLE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ddr4_cmd_dly_tap_ctrl_if.sv
// Training-engine request handshake for the command delay tap controller.
// The master issues tap requests; the slave answers with ready and done.
interface ddr4_cmd_dly_tap_ctrl_if
  import ddr4_phy_ctrl_pkg::*;
#(
  parameter int TAP_W = TAP_W_DEF
);

  logic             REQ_VALID;
  logic             REQ_READY;
  logic             REQ_LOAD;
  logic [TAP_W-1:0] REQ_TAP;
  logic             DONE;

  modport master (
    output REQ_VALID,
    output REQ_LOAD,
    output REQ_TAP,
    input  REQ_READY,
    input  DONE
  );

  modport slave (
    input  REQ_VALID,
    input  REQ_LOAD,
    input  REQ_TAP,
    output REQ_READY,
    output DONE
  );

endinterface

// File: rtl/ddr4_cmd_dly_tap_ctrl.sv
// Steps one DDR4 cmd/addr IOD delay line toward an absolute tap target,
// one tap per MOVE pulse with a settle gap, tracking tap and range errors.
module ddr4_cmd_dly_tap_ctrl
  import ddr4_phy_ctrl_pkg::*;
#(
  parameter int TAP_W         = TAP_W_DEF,
  parameter int INIT_TAP      = 1,
  parameter int MAX_TAP       = 127,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             FAB_CLK,
  input  logic             TX_SYNC_RST,
  ddr4_cmd_dly_tap_ctrl_if.slave req,
  output logic             ERR_OOR,
  output logic [TAP_W-1:0] CUR_TAP,
  output logic             BUSY,
  output logic             DELAY_LINE_MOVE_0,
  output logic             DELAY_LINE_DIRECTION_0,
  output logic             DELAY_LINE_LOAD_0,
  input  logic             DELAY_LINE_OUT_OF_RANGE_0
);

  localparam logic [TAP_W-1:0] INIT_T = TAP_W'(INIT_TAP);
  localparam logic [TAP_W-1:0] MAX_T  = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] ONE_T  = TAP_W'(1);
  localparam logic [3:0]       S_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           state_n;
  logic [3:0]       cnt;
  logic [TAP_W-1:0] target;
  logic [TAP_W-1:0] tgt_c;
  logic             dir;
  logic             from_load;
  logic             auto_ld;
  logic             armed;
  logic             accept;
  logic             oor;
  logic             last;

  assign tgt_c  = (req.REQ_TAP > MAX_T) ? MAX_T : req.REQ_TAP;
  assign accept = (state == ST_IDLE) && req.REQ_VALID;
  assign oor    = DELAY_LINE_OUT_OF_RANGE_0;
  assign last   = (cnt == 4'd0);

  assign req.REQ_READY          = (state == ST_IDLE);
  assign req.DONE               = (state == ST_DONE);
  assign BUSY                   = (state != ST_IDLE);
  assign DELAY_LINE_MOVE_0      = (state == ST_MOVE);
  // armed holds LOAD low for the cycle in which reset is released
  assign DELAY_LINE_LOAD_0      = (state == ST_LOAD) && !armed;
  assign DELAY_LINE_DIRECTION_0 = dir;

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req.REQ_LOAD)
            state_n = ST_LOAD;
          else if (tgt_c == CUR_TAP)
            state_n = ST_DONE;
          else
            state_n = ST_SETUP;
        end
      end
      ST_SETUP:  state_n = ST_MOVE;
      ST_MOVE:   state_n = ST_SETTLE;
      ST_LOAD: begin
        if (!armed)
          state_n = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (oor || last) begin
          if (auto_ld)
            state_n = ST_IDLE;
          else if (oor || from_load || CUR_TAP == target)
            state_n = ST_DONE;
          else
            state_n = ST_MOVE;
        end
      end
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      state     <= ST_LOAD;
      CUR_TAP   <= INIT_T;
      target    <= INIT_T;
      ERR_OOR   <= 1'b0;
      dir       <= DIR_DEC;
      cnt       <= 4'd0;
      from_load <= 1'b1;
      auto_ld   <= 1'b1;
      armed     <= 1'b1;
    end else begin
      state <= state_n;
      armed <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          auto_ld <= 1'b0;
          if (accept) begin
            if (req.REQ_LOAD) begin
              ERR_OOR <= 1'b0;
            end else begin
              target <= tgt_c;
              dir    <= (tgt_c > CUR_TAP) ? DIR_INC : DIR_DEC;
            end
          end
        end
        ST_MOVE: begin
          CUR_TAP   <= (dir == DIR_INC) ? CUR_TAP + ONE_T
                                        : CUR_TAP - ONE_T;
          cnt       <= S_LAST;
          from_load <= 1'b0;
        end
        ST_LOAD: begin
          CUR_TAP   <= INIT_T;
          cnt       <= S_LAST;
          from_load <= 1'b1;
        end
        ST_SETTLE: begin
          cnt <= cnt - 4'd1;
          // undo the step the IOD refused; a LOAD leaves INIT_TAP in place
          if (oor) begin
            ERR_OOR <= 1'b1;
            if (!from_load)
              CUR_TAP <= (dir == DIR_INC) ? CUR_TAP - ONE_T
                                          : CUR_TAP + ONE_T;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr4_cmd_dly_tap_ctrl.sv
// Directed bench for ddr4_cmd_dly_tap_ctrl: request table plus
// hand-written reset, busy-ignore and out-of-range sequences.
module tb_ddr4_cmd_dly_tap_ctrl;
  import ddr4_phy_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dl_oor = 1'b0;
  logic       err_oor;
  logic [7:0] cur_tap;
  logic       busy;
  logic       dl_move;
  logic       dl_dir;
  logic       dl_load;

  int n_run  = 0;
  int n_fail = 0;

  ddr4_cmd_dly_tap_ctrl_if #(.TAP_W(8)) bus ();

  ddr4_cmd_dly_tap_ctrl #(
    .TAP_W(8),
    .INIT_TAP(1),
    .MAX_TAP(127),
    .SETTLE_CYCLES(4)
  ) dut (
    .FAB_CLK(clk),
    .TX_SYNC_RST(rst),
    .req(bus),
    .ERR_OOR(err_oor),
    .CUR_TAP(cur_tap),
    .BUSY(busy),
    .DELAY_LINE_MOVE_0(dl_move),
    .DELAY_LINE_DIRECTION_0(dl_dir),
    .DELAY_LINE_LOAD_0(dl_load),
    .DELAY_LINE_OUT_OF_RANGE_0(dl_oor)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ld;
    int   tap;
    int   oor_at;
    int   e_done;
    int   e_moves;
    int   e_loads;
    int   e_cur;
    int   e_err;
    int   e_dir;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_req(
    input  logic ld,
    input  int   tap,
    input  int   oor_at,
    input  bit   hold,
    input  int   hold_tap,
    output int   done_cyc,
    output int   moves,
    output int   loads,
    output int   dir1
  );
    int k;
    logic [7:0] t8;
    k = 0;
    while (!bus.REQ_READY && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_req", int'(bus.REQ_READY), 1);
    t8 = tap[7:0];
    bus.REQ_VALID = 1'b1;
    bus.REQ_LOAD  = ld;
    bus.REQ_TAP   = t8;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      t8 = hold_tap[7:0];
      bus.REQ_TAP = t8;
    end else begin
      bus.REQ_VALID = 1'b0;
    end
    done_cyc = -1;
    moves    = 0;
    loads    = 0;
    dir1     = -1;
    for (int c = 1; c <= 1000 && done_cyc < 0; c++) begin
      if (c > 1) @(negedge clk);
      dl_oor = (oor_at == c);
      if (c == 1) dir1 = int'(dl_dir);
      moves += int'(dl_move);
      loads += int'(dl_load);
      if (bus.DONE) begin
        done_cyc = c;
        bus.REQ_VALID = 1'b0;
      end
    end
    dl_oor = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, mv, ld, d1;
    int load_cyc, ready_cyc, dones;

    vt[0] = '{1'b0,   4, 0,  17,   3, 0,   4, 0,  1};
    vt[1] = '{1'b0,   2, 0,  12,   2, 0,   2, 0,  0};
    vt[2] = '{1'b0,   2, 0,   1,   0, 0,   2, 0, -1};
    vt[3] = '{1'b1,   0, 0,   6,   0, 1,   1, 0, -1};
    vt[4] = '{1'b0,  10, 9,  10,   2, 0,   2, 1,  1};
    vt[5] = '{1'b1,   0, 0,   6,   0, 1,   1, 0, -1};
    vt[6] = '{1'b0, 126, 0, 627, 125, 0, 126, 0,  1};
    vt[7] = '{1'b0, 200, 0,   7,   1, 0, 127, 0,  1};
    vt[8] = '{1'b0,   0, 0, 637, 127, 0,   0, 0,  0};
    vt[9] = '{1'b0,   1, 0,   7,   1, 0,   1, 0,  1};

    bus.REQ_VALID = 1'b0;
    bus.REQ_LOAD  = 1'b0;
    bus.REQ_TAP   = 8'd0;

    // power-on reset and auto-load
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cur_tap", int'(cur_tap), 1);
    chk("rst_busy",    int'(busy), 1);
    chk("rst_ready",   int'(bus.REQ_READY), 0);
    chk("rst_move",    int'(dl_move), 0);
    chk("rst_load",    int'(dl_load), 0);
    chk("rst_done",    int'(bus.DONE), 0);
    chk("rst_err",     int'(err_oor), 0);
    rst = 1'b0;
    load_cyc  = -1;
    ready_cyc = -1;
    dones = 0;
    ld    = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (dl_load && load_cyc < 0) load_cyc = c;
      if (bus.REQ_READY && ready_cyc < 0) ready_cyc = c;
      ld    += int'(dl_load);
      dones += int'(bus.DONE);
    end
    chk("auto_load_cycle", load_cyc, 1);
    chk("auto_load_count", ld, 1);
    chk("auto_ready_cycle", ready_cyc, 6);
    chk("auto_no_done", dones, 0);
    chk("auto_cur_tap", int'(cur_tap), 1);

    for (int i = 0; i < 10; i++) begin
      run_req(vt[i].ld, vt[i].tap, vt[i].oor_at, 1'b0, 0,
              dc, mv, ld, d1);
      chk($sformatf("v%0d_done_cycle", i), dc, vt[i].e_done);
      chk($sformatf("v%0d_moves", i), mv, vt[i].e_moves);
      chk($sformatf("v%0d_loads", i), ld, vt[i].e_loads);
      chk($sformatf("v%0d_cur_tap", i), int'(cur_tap), vt[i].e_cur);
      chk($sformatf("v%0d_err_oor", i), int'(err_oor), vt[i].e_err);
      if (vt[i].e_dir >= 0)
        chk($sformatf("v%0d_dir", i), d1, vt[i].e_dir);
    end

    // REQ_VALID held high with a new tap while busy must be ignored
    run_req(1'b0, 3, 0, 1'b1, 20, dc, mv, ld, d1);
    chk("hold_done_cycle", dc, 12);
    chk("hold_moves", mv, 2);
    chk("hold_cur_tap", int'(cur_tap), 3);

    // reset in the middle of a 3-tap move
    @(negedge clk);
    bus.REQ_VALID = 1'b1;
    bus.REQ_LOAD  = 1'b0;
    bus.REQ_TAP   = 8'd6;
    @(posedge clk);
    mv = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      mv += int'(dl_move);
    end
    chk("abort_moves_before", mv, 2);
    chk("abort_cur_before", int'(cur_tap), 5);
    rst = 1'b1;
    bus.REQ_VALID = 1'b0;
    @(negedge clk);
    chk("abort_move",  int'(dl_move), 0);
    chk("abort_done",  int'(bus.DONE), 0);
    chk("abort_err",   int'(err_oor), 0);
    chk("abort_cur",   int'(cur_tap), 1);
    chk("abort_load",  int'(dl_load), 0);
    chk("abort_ready", int'(bus.REQ_READY), 0);
    rst = 1'b0;
    load_cyc = -1;
    ld = 0;
    dones = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (dl_load && load_cyc < 0) load_cyc = c;
      ld    += int'(dl_load);
      dones += int'(bus.DONE);
    end
    chk("reload_cycle", load_cyc, 1);
    chk("reload_count", ld, 1);
    chk("reload_no_done", dones, 0);

    run_req(1'b0, 2, 0, 1'b0, 0, dc, mv, ld, d1);
    chk("post_abort_done", dc, 7);
    chk("post_abort_cur", int'(cur_tap), 2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr4_cmd_dly_tap_ctrl.md
Name: ddr4_cmd_dly_tap_ctrl

Overview:
Fabric-side controller that drives the dynamic delay-line controls of one DDR4 address/command IOD lane: DELAY_LINE_MOVE, DELAY_LINE_DIRECTION and DELAY_LINE_LOAD. It sits directly upstream of the command-pin IOD. It accepts absolute tap-target requests from the training engine and steps the delay line one tap at a time, with a settle gap after each step. It tracks the current tap and reports out-of-range errors returned by the IOD.

Parameters:
TAP_W, 8, width of tap codes
INIT_TAP, 1, tap value after LOAD; matches the IOD static TX delay value
MAX_TAP, 127, highest legal target; larger requests are clamped
SETTLE_CYCLES, 4, idle cycles after each MOVE or LOAD pulse (legal range 1 to 15)

Ports:
FAB_CLK  in  1  fabric clock; the only clock
TX_SYNC_RST  in  1  synchronous, active-high reset
REQ_VALID  in  1  request strobe
REQ_READY  out  1  high only in IDLE
REQ_LOAD  in  1  with REQ_VALID: reload the delay line to INIT_TAP; takes priority over REQ_TAP
REQ_TAP  in  TAP_W  absolute target tap
DONE  out  1  one-cycle pulse when a request completes
ERR_OOR  out  1  sticky out-of-range flag
CUR_TAP  out  TAP_W  tracked current tap
BUSY  out  1  high whenever the state is not IDLE
DELAY_LINE_MOVE_0  out  1  one-cycle step pulse to the IOD
DELAY_LINE_DIRECTION_0  out  1  step direction: 1 = increment, 0 = decrement
DELAY_LINE_LOAD_0  out  1  one-cycle reload pulse to the IOD
DELAY_LINE_OUT_OF_RANGE_0  in  1  out-of-range status from the IOD

Behaviour:
- Single clock domain FAB_CLK. Reset is synchronous, active-high, on TX_SYNC_RST.
- Reset values:
  - MOVE, LOAD, DIRECTION, DONE, ERR_OOR and REQ_READY are all 0.
  - CUR_TAP = INIT_TAP; BUSY = 1; state = LOAD.
- Post-reset auto-load:
  - The first cycle after reset deasserts emits a LOAD pulse, so hardware and CUR_TAP agree.
  - It is followed by SETTLE, then IDLE.
  - No DONE pulse is produced for the auto-load.
- Reset asserted mid-operation aborts immediately and restores all reset values. Any pending DONE is dropped.
- State IDLE: REQ_READY = 1. A request is accepted on REQ_VALID & REQ_READY.
  - If REQ_LOAD = 1: clear ERR_OOR and go to LOAD.
  - Otherwise, latch TARGET = min(REQ_TAP, MAX_TAP).
    - If TARGET == CUR_TAP: go to DONE.
    - Otherwise: register DIRECTION = (TARGET > CUR_TAP) and go to SETUP.
- State SETUP: one cycle; lets DIRECTION settle ahead of the first MOVE. Go to MOVE.
- State MOVE: assert MOVE for one cycle. CUR_TAP steps by ±1, updating on the MOVE cycle. Go to SETTLE.
- State LOAD: assert LOAD for one cycle and set CUR_TAP = INIT_TAP. Go to SETTLE.
- State SETTLE: lasts SETTLE_CYCLES cycles. OUT_OF_RANGE is sampled every settle cycle.
  - If OUT_OF_RANGE is seen high:
    - set ERR_OOR;
    - revert CUR_TAP by the last step (for a LOAD, CUR_TAP stays at INIT_TAP);
    - go to DONE.
  - On the last settle cycle: go to DONE if CUR_TAP == TARGET (or the entry was from LOAD), otherwise go to MOVE.
- State DONE: DONE = 1 for one cycle, then IDLE.
- DIRECTION holds its value until the next accepted move request. Its value outside a move is don't-care.
- MOVE and LOAD are never asserted in the same cycle.
- Latency, counting the accept cycle as 0, with S = SETTLE_CYCLES:
  - N-tap move: DONE at cycle 1 + N*(1+S) + 1. For S = 4 that is 5N + 2.
  - Zero-tap request: DONE at cycle 1.
  - LOAD request: DONE at cycle 2 + S.
- CUR_TAP arithmetic: TAP_W bits. Because TARGET is clamped to MAX_TAP, CUR_TAP never wraps, neither below 0 nor above MAX_TAP.
- REQ_VALID while BUSY is ignored; no queuing.

Decomposition:
- Shared package ddr4_phy_ctrl_pkg holds:
  - the state enum (IDLE, SETUP, MOVE, LOAD, SETTLE, DONE);
  - constants DIR_INC = 1 and DIR_DEC = 0;
  - the default TAP_W.
- No sub-module: the settle counter and the state machine live in one module.

Test Plan:
- Reset release -> LOAD pulse on cycle 1; CUR_TAP = 1; REQ_READY rises at cycle 6 (S = 4); no DONE.
- From CUR_TAP = 1, request REQ_TAP = 4 -> DIRECTION = 1 from cycle 1; MOVE pulses at cycles 2, 7, 12; DONE at cycle 17; CUR_TAP = 4; ERR_OOR = 0.
- From CUR_TAP = 4, request REQ_TAP = 2 -> DIRECTION = 0; 2 MOVE pulses; DONE at cycle 12; CUR_TAP = 2.
- Request REQ_TAP = 200 from CUR_TAP = 126 -> clamped to 127; 1 MOVE pulse; DONE at cycle 7; CUR_TAP = 127.
- From CUR_TAP = 1, request REQ_TAP = 10; OUT_OF_RANGE driven high in the second SETTLE window -> no third MOVE; DONE pulse; CUR_TAP = 2; ERR_OOR = 1. A following LOAD request clears ERR_OOR and gives DONE at cycle 6 with CUR_TAP = 1.
- Reset asserted at cycle 8 of a 3-tap move -> the next cycle shows MOVE = 0, DONE = 0, ERR_OOR = 0, CUR_TAP = 1; the auto-load LOAD pulse follows reset release. REQ_VALID held high while BUSY is ignored (no extra MOVE).
